imem_loader: RTL and testbench

Boot-time instruction-memory loader sitting directly upstream of the single-cycle RISC-V core. It accepts a byte stream (valid/ready), checks a length header, assembles little-endian 32-bit words and writes them into the 256-word instruction memory, holding the core in reset. After the trailing checksum verifies, it releases the core and enables fetch. On any protocol error it halts with the core held in reset.

---
 rtl/imem_loader_if.sv | 21 ++
 rtl/imem_loader.sv | 93 +++++++++
 tb/tb_imem_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input, imem write bus and core control of the instruction-memory loader
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              core_enable;
  logic              done;
  logic              err;
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst, core_enable, done, err
  );
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_rst, core_enable, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot loader streaming a length-prefixed, checksummed image into instruction memory
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic        clk,
  input logic        rst,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {LEN0, LEN1, DATA, CHK, RUN, ERR} state_t;
  state_t          state;
  logic [7:0]      len_lo;
  logic [15:0]     n;
  logic [ADDR_W:0] word_idx;
  logic [1:0]      byte_idx;
  logic [7:0]      sum;
  logic [31:0]     wbuf;
  logic [15:0]     len;
  logic [15:0]     next_cnt;
  logic            take;
  assign len      = {bus.rx_data, len_lo};
  assign next_cnt = 16'(word_idx) + 16'd1;
  assign take     = bus.rx_valid && bus.rx_ready;
  // Loader FSM: every output is registered; the imem write path runs alongside byte intake
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= LEN0;
      len_lo          <= '0;
      n               <= '0;
      word_idx        <= '0;
      byte_idx        <= '0;
      sum             <= '0;
      wbuf            <= '0;
      bus.rx_ready    <= 1'b1;
      bus.imem_we     <= 1'b0;
      bus.imem_addr   <= '0;
      bus.imem_wdata  <= '0;
      bus.core_rst    <= 1'b1;
      bus.core_enable <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      if (take) begin
        case (state)
          LEN0: begin
            len_lo <= bus.rx_data;
            state  <= LEN1;
          end
          LEN1: begin
            n <= len;
            if (len == 16'd0 || len > 16'(DEPTH)) begin
              state        <= ERR;
              bus.rx_ready <= 1'b0;
              bus.err      <= 1'b1;
            end else begin
              word_idx <= '0;
              byte_idx <= '0;
              sum      <= '0;
              state    <= DATA;
            end
          end
          DATA: begin
            sum      <= sum + bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_idx[ADDR_W-1:0];
              bus.imem_wdata <= {bus.rx_data, wbuf[23:0]};
              word_idx       <= word_idx + 1'b1;
              if (next_cnt == n) state <= CHK;
            end else begin
              wbuf[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
            end
          end
          CHK: begin
            bus.rx_ready <= 1'b0;
            if (bus.rx_data == sum) begin
              state           <= RUN;
              bus.core_rst    <= 1'b0;
              bus.core_enable <= 1'b1;
              bus.done        <= 1'b1;
            end else begin
              state   <= ERR;
              bus.err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed tests of the instruction-memory loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  imem_loader_if bus();
  imem_loader u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int compared = 0;
  int mismatched = 0;
  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  int   dbl = 0;
  logic prev_we = 1'b0;
  logic [7:0] good [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
  // write log sampled mid-cycle; dbl counts strobes lasting more than one cycle
  always @(negedge clk) begin
    if (bus.imem_we) begin
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_wdata);
      if (prev_we) dbl++;
    end
    prev_we = bus.imem_we;
  end
  task put(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask
  task do_reset;
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task settle;
    repeat (2) begin @(posedge clk); #1; end
  endtask
  task test_reset;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    compared++;
    if ({bus.rx_ready, bus.core_rst, bus.imem_we, bus.core_enable, bus.done, bus.err, bus.imem_addr, bus.imem_wdata} !== {6'b110000, 8'h00, 32'h0}) begin
      mismatched++;
      $display("FAIL reset_vals: got %b %h %h want 110000 00 00000000", {bus.rx_ready, bus.core_rst, bus.imem_we, bus.core_enable, bus.done, bus.err}, bus.imem_addr, bus.imem_wdata);
    end
  endtask
  task test_good_load;
    int ws;
    do_reset;
    ws = wa.size();
    for (int i = 0; i < 11; i++) begin
      put(good[i], 0);
      if (i == 5) begin
        compared++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 8'h00, 32'h00000013}) begin
          mismatched++;
          $display("FAIL good_w0: got we=%b a=%h d=%h want we=1 a=00 d=00000013", bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
      end
      if (i == 9) begin
        compared++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.done} !== {1'b1, 8'h01, 32'h00100093, 1'b0}) begin
          mismatched++;
          $display("FAIL good_w1: got we=%b a=%h d=%h done=%b want we=1 a=01 d=00100093 done=0", bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.done);
        end
      end
      if (i == 10) begin
        compared++;
        if ({bus.done, bus.core_rst, bus.core_enable, bus.rx_ready, bus.err, bus.imem_we} !== 6'b101000) begin
          mismatched++;
          $display("FAIL good_release: got done,crst,cen,rdy,err,we=%b want 101000", {bus.done, bus.core_rst, bus.core_enable, bus.rx_ready, bus.err, bus.imem_we});
        end
      end
    end
    settle;
    compared++;
    if (wa.size() - ws !== 2) begin
      mismatched++;
      $display("FAIL good_wcount: got %0d want 2", wa.size() - ws);
    end
  endtask
  task test_bad_checksum;
    int ws;
    do_reset;
    ws = wa.size();
    for (int i = 0; i < 10; i++) put(good[i], 0);
    put(8'hB7, 0);
    compared++;
    if ({bus.err, bus.core_rst, bus.rx_ready, bus.done, bus.core_enable} !== 5'b11000) begin
      mismatched++;
      $display("FAIL bad_chk_state: got err,crst,rdy,done,cen=%b want 11000", {bus.err, bus.core_rst, bus.rx_ready, bus.done, bus.core_enable});
    end
    for (int i = 0; i < 3; i++) put(8'hAA, 0);
    settle;
    compared++;
    if (wa.size() - ws !== 2 || wa[ws] !== 8'h00 || wd[ws] !== 32'h00000013 || wa[ws+1] !== 8'h01 || wd[ws+1] !== 32'h00100093) begin
      mismatched++;
      $display("FAIL bad_chk_writes: got count=%0d want 2 writes 00:00000013 01:00100093", wa.size() - ws);
    end
    compared++;
    if ({bus.err, bus.rx_ready, bus.core_rst} !== 3'b101) begin
      mismatched++;
      $display("FAIL bad_chk_sticky: got err,rdy,crst=%b want 101", {bus.err, bus.rx_ready, bus.core_rst});
    end
  endtask
  task test_len_limits;
    int ws;
    logic [7:0] sum;
    logic [7:0] bi;
    int bad;
    do_reset;
    ws = wa.size();
    put(8'h00, 0);
    put(8'h00, 0);
    compared++;
    if ({bus.err, bus.rx_ready, bus.core_rst} !== 3'b101) begin
      mismatched++;
      $display("FAIL len_zero: got err,rdy,crst=%b want 101", {bus.err, bus.rx_ready, bus.core_rst});
    end
    put(8'h11, 0);
    settle;
    compared++;
    if (wa.size() - ws !== 0) begin
      mismatched++;
      $display("FAIL len_zero_writes: got %0d want 0", wa.size() - ws);
    end
    do_reset;
    put(8'h2C, 0);
    compared++;
    if (bus.err !== 1'b0) begin
      mismatched++;
      $display("FAIL len_300_early: got err=%b want 0", bus.err);
    end
    put(8'h01, 0);
    compared++;
    if ({bus.err, bus.rx_ready} !== 2'b10) begin
      mismatched++;
      $display("FAIL len_300: got err,rdy=%b want 10", {bus.err, bus.rx_ready});
    end
    do_reset;
    ws = wa.size();
    sum = 8'h00;
    put(8'h00, 0);
    put(8'h01, 0);
    for (int i = 0; i < 256; i++) begin
      bi = 8'(i);
      put(bi, 0);
      put(8'h00, 0);
      put(8'h00, 0);
      put(8'hA5, 0);
      sum = sum + bi + 8'hA5;
    end
    put(sum, 0);
    settle;
    compared++;
    if (wa.size() - ws !== 256) begin
      mismatched++;
      $display("FAIL len_256_count: got %0d want 256", wa.size() - ws);
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        bi = 8'(i);
        if (wa[ws+i] !== bi || wd[ws+i] !== {8'hA5, 16'h0000, bi}) bad++;
      end
      if (bad != 0) begin
        mismatched++;
        $display("FAIL len_256_data: got %0d bad entries want 0", bad);
      end
    end
    compared++;
    if ({bus.done, bus.err, bus.core_rst} !== 3'b100) begin
      mismatched++;
      $display("FAIL len_256_done: got done,err,crst=%b want 100", {bus.done, bus.err, bus.core_rst});
    end
  endtask
  task test_throttle;
    int ws;
    int d0;
    do_reset;
    ws = wa.size();
    d0 = dbl;
    for (int i = 0; i < 11; i++) put(good[i], 3);
    settle;
    compared++;
    if (wa.size() - ws !== 2 || wa[ws] !== 8'h00 || wd[ws] !== 32'h00000013 || wa[ws+1] !== 8'h01 || wd[ws+1] !== 32'h00100093) begin
      mismatched++;
      $display("FAIL throttle_writes: got count=%0d want 2 writes 00:00000013 01:00100093", wa.size() - ws);
    end
    compared++;
    if ({bus.done, bus.core_enable, bus.core_rst} !== 3'b110) begin
      mismatched++;
      $display("FAIL throttle_done: got done,cen,crst=%b want 110", {bus.done, bus.core_enable, bus.core_rst});
    end
    compared++;
    if (dbl - d0 !== 0) begin
      mismatched++;
      $display("FAIL throttle_we_width: got %0d long strobes want 0", dbl - d0);
    end
  endtask
  task test_mid_reset;
    int ws;
    do_reset;
    ws = wa.size();
    for (int i = 0; i < 8; i++) put(good[i], 0);
    do_reset;
    compared++;
    if ({bus.rx_ready, bus.core_rst, bus.imem_we, bus.core_enable, bus.done, bus.err, bus.imem_addr, bus.imem_wdata} !== {6'b110000, 8'h00, 32'h0}) begin
      mismatched++;
      $display("FAIL midrst_vals: got %b %h %h want 110000 00 00000000", {bus.rx_ready, bus.core_rst, bus.imem_we, bus.core_enable, bus.done, bus.err}, bus.imem_addr, bus.imem_wdata);
    end
    settle;
    compared++;
    if (wa.size() - ws !== 1 || wa[ws] !== 8'h00 || wd[ws] !== 32'h00000013) begin
      mismatched++;
      $display("FAIL midrst_writes: got count=%0d want 1 write 00:00000013", wa.size() - ws);
    end
    ws = wa.size();
    for (int i = 0; i < 11; i++) put(good[i], 0);
    settle;
    compared++;
    if (wa.size() - ws !== 2 || wa[ws] !== 8'h00 || wa[ws+1] !== 8'h01 || wd[ws+1] !== 32'h00100093 || bus.done !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_reload: got count=%0d done=%b want 2 writes done=1", wa.size() - ws, bus.done);
    end
    do_reset;
    for (int i = 0; i < 5; i++) put(good[i], 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = good[5];
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    compared++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b0, 8'h00, 32'h0}) begin
      mismatched++;
      $display("FAIL midrst_cancel: got we=%b a=%h d=%h want we=0 a=00 d=00000000", bus.imem_we, bus.imem_addr, bus.imem_wdata);
    end
  endtask
  task test_post_terminal;
    int ws;
    do_reset;
    for (int i = 0; i < 11; i++) put(good[i], 0);
    settle;
    ws = wa.size();
    for (int i = 0; i < 5; i++) begin
      put(8'($urandom), 0);
      compared++;
      if ({bus.rx_ready, bus.done, bus.imem_we, bus.core_rst} !== 4'b0100) begin
        mismatched++;
        $display("FAIL post_run_%0d: got rdy,done,we,crst=%b want 0100", i, {bus.rx_ready, bus.done, bus.imem_we, bus.core_rst});
      end
    end
    settle;
    compared++;
    if (wa.size() - ws !== 0) begin
      mismatched++;
      $display("FAIL post_run_writes: got %0d want 0", wa.size() - ws);
    end
    do_reset;
    compared++;
    if ({bus.core_rst, bus.done, bus.core_enable, bus.rx_ready} !== 4'b1001) begin
      mismatched++;
      $display("FAIL post_run_rst: got crst,done,cen,rdy=%b want 1001", {bus.core_rst, bus.done, bus.core_enable, bus.rx_ready});
    end
  endtask
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset;
    test_good_load;
    test_bad_checksum;
    test_len_limits;
    test_throttle;
    test_mid_reset;
    test_post_terminal;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
